// File: rtl/code_stim_pkg.sv
// Shared types and default sizes for the code-unit stimulus sequencer.
//   cmd_t   : one program entry {slt, en, len}; the segment lasts len+1 cycles
//   state_t : sequencer states
//   DEF_*   : default program depth and length-field width
package code_stim_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef struct packed {
    logic                 slt;
    logic                 en;
    logic [DEF_CNT_W-1:0] len;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RUN,
    SNAP,
    DONE
  } state_t;

endpackage

// File: rtl/code_stim_prog.sv
// Program store for the stimulus sequencer: DEPTH entries of {slt, en, len}.
// Owns the write pointer and the entry count. Reads are asynchronous.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : empty the program (takes priority over wr_en)
//   wr_en      : append wr_cmd when not full
//   wr_cmd     : command to append
//   rd_ptr     : entry to read
//   rd_cmd     : entry at rd_ptr
//   count      : number of stored entries (0..DEPTH)
//   full       : count == DEPTH
module code_stim_prog
  import code_stim_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CMD_W = DEF_CNT_W + 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [CMD_W-1:0] wr_cmd,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [CMD_W-1:0] rd_cmd,
  output logic [PTR_W:0]   count,
  output logic             full
);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign full   = (count_q == (PTR_W+1)'(DEPTH));
  assign count  = count_q;
  assign rd_cmd = mem_q[rd_ptr];

  // Clear beats a same-cycle write so the program is guaranteed empty after clr.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (wr_en && !full) begin
      mem_d[wr_ptr_q] = wr_cmd;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      count_d         = count_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry contents need no reset: count gates which entries are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/code_stim_seq.sv
// Stimulus sequencer for the dual 64-bit counter block (the code unit).
// Replays a loaded program of {Slt, En, len} segments, holding Slt/En for
// len+1 cycles each, then snapshots Output0/Output1 onto a valid/ready port.
// Optional feature macro: CODE_STIM_SEQ_LOOP_EN adds input Loop; with Loop
// high at the final snapshot handshake the program restarts from entry 0.
// Ports:
//   Clk, Reset        : clock, asynchronous active-low reset
//   Clr               : empty the program (IDLE only)
//   Wr_en, Wr_cmd     : append {slt, en, len} (IDLE only, dropped when full)
//   Wr_full           : program holds DEPTH entries
//   Start             : begin replay (IDLE only)
//   Busy              : sequencer not idle
//   Done              : one-cycle pulse at end of replay
//   Slt, En           : registered drives to the counter block
//   Output0, Output1  : counter block values
//   Snap_valid/ready  : snapshot handshake
//   Snap0, Snap1      : captured counter values
//   Snap_idx          : program index of the snapshot
//   Loop              : (CODE_STIM_SEQ_LOOP_EN only) repeat the program
module code_stim_seq
  import code_stim_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DATA_W = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr,
  input  logic              Wr_en,
  input  logic [CNT_W+1:0]  Wr_cmd,
  output logic              Wr_full,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              Slt,
  output logic              En,
  input  logic [DATA_W-1:0] Output0,
  input  logic [DATA_W-1:0] Output1,
  output logic              Snap_valid,
  input  logic              Snap_ready,
  output logic [DATA_W-1:0] Snap0,
  output logic [DATA_W-1:0] Snap1,
  output logic [PTR_W-1:0]  Snap_idx
`ifdef CODE_STIM_SEQ_LOOP_EN
  ,
  input  logic              Loop
`endif
);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic                slt_q, slt_d;
  logic                en_q, en_d;
  logic                done_q, done_d;
  logic                snap_valid_q, snap_valid_d;
  logic [DATA_W-1:0]   snap0_q, snap0_d;
  logic [DATA_W-1:0]   snap1_q, snap1_d;
  logic [PTR_W-1:0]    snap_idx_q, snap_idx_d;

  logic [CNT_W+1:0]    rd_cmd;
  logic [PTR_W:0]      prog_cnt;
  logic                is_idle;
  logic                last_entry;
  logic                loop_sel;

  assign is_idle    = (state_q == IDLE);
  assign last_entry = ({1'b0, rd_ptr_q} == (prog_cnt - (PTR_W+1)'(1)));

`ifdef CODE_STIM_SEQ_LOOP_EN
  assign loop_sel = Loop;
`else
  assign loop_sel = 1'b0;
`endif

  // Program edits are only allowed while idle so a replay never sees a moving program.
  code_stim_prog #(
    .DEPTH (DEPTH),
    .CMD_W (CNT_W + 2)
  ) u_prog (
    .clk    (Clk),
    .rst_n  (Reset),
    .clr    (Clr && is_idle),
    .wr_en  (Wr_en && is_idle),
    .wr_cmd (Wr_cmd),
    .rd_ptr (rd_ptr_q),
    .rd_cmd (rd_cmd),
    .count  (prog_cnt),
    .full   (Wr_full)
  );

  // run_cnt counts down from len to 0, so a segment lasts len+1 cycles
  // without ever needing a counter wider than the len field.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    run_cnt_d    = run_cnt_q;
    slt_d        = slt_q;
    en_d         = en_q;
    done_d       = 1'b0;
    snap_valid_d = snap_valid_q;
    snap0_d      = snap0_q;
    snap1_d      = snap1_q;
    snap_idx_d   = snap_idx_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (prog_cnt != '0) state_d = FETCH;
          else                done_d  = 1'b1;
        end
      end
      FETCH: begin
        slt_d     = rd_cmd[CNT_W+1];
        en_d      = rd_cmd[CNT_W];
        run_cnt_d = rd_cmd[CNT_W-1:0];
        state_d   = RUN;
      end
      RUN: begin
        if (run_cnt_q == '0) begin
          en_d         = 1'b0;
          snap0_d      = Output0;
          snap1_d      = Output1;
          snap_idx_d   = rd_ptr_q;
          snap_valid_d = 1'b1;
          state_d      = SNAP;
        end else begin
          run_cnt_d = run_cnt_q - CNT_W'(1);
        end
      end
      SNAP: begin
        if (snap_valid_q && Snap_ready) begin
          snap_valid_d = 1'b0;
          if (!last_entry) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            state_d  = FETCH;
          end else if (loop_sel) begin
            rd_ptr_d = '0;
            state_d  = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rd_ptr_d = '0;
        slt_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      run_cnt_q    <= '0;
      slt_q        <= 1'b0;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      snap0_q      <= '0;
      snap1_q      <= '0;
      snap_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      run_cnt_q    <= run_cnt_d;
      slt_q        <= slt_d;
      en_q         <= en_d;
      done_q       <= done_d;
      snap_valid_q <= snap_valid_d;
      snap0_q      <= snap0_d;
      snap1_q      <= snap1_d;
      snap_idx_q   <= snap_idx_d;
    end
  end

  assign Busy       = !is_idle;
  assign Done       = done_q;
  assign Slt        = slt_q;
  assign En         = en_q;
  assign Snap_valid = snap_valid_q;
  assign Snap0      = snap0_q;
  assign Snap1      = snap1_q;
  assign Snap_idx   = snap_idx_q;

endmodule

// File: tb/tb_code_stim_seq.sv
// Self-checking bench for code_stim_seq with a behavioural dual counter.
// Expected snapshots come from per-counter running totals: each enabled
// segment adds len+1 to the counter picked by its slt; a snapshot taken at
// the end of a segment sees that segment's len increments (its last one
// lands on the same edge the snapshot is captured).
module tb_code_stim_seq;
  import code_stim_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 clr;
  logic                 wr_en;
  logic [DEF_CNT_W+1:0] wr_cmd;
  logic                 wr_full;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 slt;
  logic                 en;
  logic [63:0]          out0;
  logic [63:0]          out1;
  logic                 snap_valid;
  logic                 snap_ready;
  logic [63:0]          snap0;
  logic [63:0]          snap1;
  logic [2:0]           snap_idx;
`ifdef CODE_STIM_SEQ_LOOP_EN
  logic                 loop_sel;
`endif

  int          vectors;
  int          miscompares;
  logic        prog_slt [8];
  logic        prog_en  [8];
  logic [7:0]  prog_len [8];
  int          prog_n;
  logic [63:0] acc0;
  logic [63:0] acc1;

  code_stim_seq dut (
    .Clk        (clk),
    .Reset      (rst_n),
    .Clr        (clr),
    .Wr_en      (wr_en),
    .Wr_cmd     (wr_cmd),
    .Wr_full    (wr_full),
    .Start      (start),
    .Busy       (busy),
    .Done       (done),
    .Slt        (slt),
    .En         (en),
    .Output0    (out0),
    .Output1    (out1),
    .Snap_valid (snap_valid),
    .Snap_ready (snap_ready),
    .Snap0      (snap0),
    .Snap1      (snap1),
    .Snap_idx   (snap_idx)
`ifdef CODE_STIM_SEQ_LOOP_EN
    ,
    .Loop       (loop_sel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counter block: Slt picks which counter En advances.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0 <= '0;
      out1 <= '0;
    end else if (en) begin
      if (slt) out1 <= out1 + 64'd1;
      else     out0 <= out0 + 64'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; the write lands on the next rising edge.
  task automatic writeCmd(input logic s, input logic e, input logic [7:0] len);
    cmd_t c;
    c.slt  = s;
    c.en   = e;
    c.len  = len;
    wr_en  = 1'b1;
    wr_cmd = c;
    @(negedge clk);
    wr_en  = 1'b0;
    if (prog_n < 8) begin
      prog_slt[prog_n] = s;
      prog_en[prog_n]  = e;
      prog_len[prog_n] = len;
      prog_n++;
    end
  endtask

  // Optionally collides a write with the clear; the clear must win.
  task automatic clearProgram(input bit with_write);
    clr    = 1'b1;
    wr_en  = with_write;
    wr_cmd = (DEF_CNT_W+2)'($urandom);
    @(negedge clk);
    clr    = 1'b0;
    wr_en  = 1'b0;
    prog_n = 0;
    checkOutput("full_after_clr", {63'd0, wr_full}, 64'd0);
  endtask

  // Starts a replay and follows it to Done, checking every snapshot.
  // stall_first holds Snap_ready low for that many cycles on the first
  // snapshot; noise throws Start/Clr/writes at the busy sequencer.
  task automatic applyStimulus(input int passes, input int ready_pct, input int stall_first, input bit noise);
    int          seg;
    int          pass;
    int          hs;
    int          done_cnt;
    int          en_cycles;
    int          stall_left;
    bit          fin;
    bit          prev_hs;
    logic        s;
    logic        e;
    logic [7:0]  len;
    logic [63:0] inc;
    logic [63:0] e0;
    logic [63:0] e1;
    seg = 0; pass = 0; hs = 0; done_cnt = 0; en_cycles = 0;
    stall_left = stall_first; fin = 1'b0; prev_hs = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (prev_hs) checkOutput("valid_drop", {63'd0, snap_valid}, 64'd0);
      prev_hs = 1'b0;
      if (en) en_cycles++;
      if (done) begin
        done_cnt++;
        fin = 1'b1;
      end
`ifdef CODE_STIM_SEQ_LOOP_EN
      loop_sel = (pass < passes - 1);
`endif
      if (snap_valid) begin
        s   = prog_slt[seg];
        e   = prog_en[seg];
        len = prog_len[seg];
        inc = e ? {56'd0, len} : 64'd0;
        e0  = s ? acc0 : acc0 + inc;
        e1  = s ? acc1 + inc : acc1;
        checkOutput("snap0", snap0, e0);
        checkOutput("snap1", snap1, e1);
        checkOutput("en_in_snap", {63'd0, en}, 64'd0);
        if (stall_left > 0) begin
          stall_left--;
          snap_ready = 1'b0;
        end else begin
          snap_ready = ($urandom_range(99) < ready_pct);
        end
        if (snap_ready) begin
          checkOutput("snap_idx", {61'd0, snap_idx}, 64'(seg));
          checkOutput("slt_held", {63'd0, slt}, {63'd0, s});
          checkOutput("en_cycles", 64'(en_cycles), e ? 64'(len) + 64'd1 : 64'd0);
          if (s) acc1 = acc1 + (e ? 64'(len) + 64'd1 : 64'd0);
          else   acc0 = acc0 + (e ? 64'(len) + 64'd1 : 64'd0);
          en_cycles = 0;
          prev_hs   = 1'b1;
          hs++;
          seg++;
          if (seg == prog_n) begin
            seg = 0;
            pass++;
          end
        end
      end else begin
        snap_ready = 1'($urandom_range(1));
      end
      if (noise && !fin) begin
        wr_en  = 1'($urandom_range(1));
        clr    = 1'($urandom_range(1));
        start  = 1'($urandom_range(1));
        wr_cmd = (DEF_CNT_W+2)'($urandom);
      end else begin
        wr_en = 1'b0;
        clr   = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; clr = 1'b0; start = 1'b0; snap_ready = 1'b0;
    checkOutput("handshakes", 64'(hs), 64'(passes * prog_n));
    checkOutput("done_pulses", 64'(done_cnt), 64'd1);
    checkOutput("busy_end", {63'd0, busy}, 64'd0);
    checkOutput("done_end", {63'd0, done}, 64'd0);
  endtask

  // Main sequence: reset, directed cases, then randomized programs.
  initial begin
    bit seen_en;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_cmd = '0;
    start = 1'b0; snap_ready = 1'b0;
`ifdef CODE_STIM_SEQ_LOOP_EN
    loop_sel = 1'b0;
`endif
    prog_n = 0; acc0 = '0; acc1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_en", {63'd0, en}, 64'd0);
    checkOutput("rst_slt", {63'd0, slt}, 64'd0);
    checkOutput("rst_valid", {63'd0, snap_valid}, 64'd0);
    checkOutput("rst_full", {63'd0, wr_full}, 64'd0);
    checkOutput("rst_snap0", snap0, 64'd0);
    checkOutput("rst_snap_idx", {61'd0, snap_idx}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] empty program start");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("empty_done", {63'd0, done}, 64'd1);
    checkOutput("empty_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    checkOutput("empty_done_drop", {63'd0, done}, 64'd0);
    checkOutput("empty_en", {63'd0, en}, 64'd0);

    $display("[TB] two-segment program");
    writeCmd(1'b0, 1'b1, 8'd4);
    writeCmd(1'b1, 1'b1, 8'd2);
    applyStimulus(1, 100, 0, 1'b0);
    applyStimulus(1, 50, 0, 1'b1);

    $display("[TB] overfill program");
    clearProgram(1'b1);
    for (int k = 0; k < 9; k++) begin
      writeCmd(1'(k), 1'b1, 8'(k));
      checkOutput($sformatf("full_%0d", k), {63'd0, wr_full}, (k >= 7) ? 64'd1 : 64'd0);
    end
    applyStimulus(1, 100, 0, 1'b0);

    $display("[TB] snapshot stall");
    clearProgram(1'b0);
    writeCmd(1'b0, 1'b1, 8'd3);
    writeCmd(1'b1, 1'b1, 8'd6);
    applyStimulus(1, 100, 10, 1'b0);

    $display("[TB] zero length, disabled and maximum length segments");
    clearProgram(1'b0);
    writeCmd(1'b1, 1'b0, 8'd5);
    writeCmd(1'b0, 1'b1, 8'd0);
    writeCmd(1'b1, 1'b1, 8'd255);
    applyStimulus(1, 70, 3, 1'b1);

    $display("[TB] reset mid-run");
    clearProgram(1'b0);
    for (int k = 0; k < 8; k++) writeCmd(1'b0, 1'b1, 8'd30);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_en = 1'b0;
    for (int k = 0; k < 10 && !seen_en; k++) begin
      if (en) seen_en = 1'b1;
      else    @(negedge clk);
    end
    checkOutput("en_before_reset", {63'd0, en}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_en", {63'd0, en}, 64'd0);
    checkOutput("mid_rst_slt", {63'd0, slt}, 64'd0);
    checkOutput("mid_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("mid_rst_valid", {63'd0, snap_valid}, 64'd0);
    checkOutput("mid_rst_full", {63'd0, wr_full}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prog_n = 0; acc0 = '0; acc1 = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("post_rst_done", {63'd0, done}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("post_rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("post_rst_en", {63'd0, en}, 64'd0);
      @(negedge clk);
    end
    writeCmd(1'b1, 1'b1, 8'd7);
    applyStimulus(1, 100, 0, 1'b0);

`ifdef CODE_STIM_SEQ_LOOP_EN
    $display("[TB] looping replay");
    clearProgram(1'b0);
    writeCmd(1'b0, 1'b1, 8'd2);
    writeCmd(1'b1, 1'b1, 8'd1);
    applyStimulus(3, 100, 0, 1'b0);
`endif

    $display("[TB] randomized programs");
    for (int r = 0; r < 6; r++) begin
      int n;
      clearProgram(1'($urandom_range(1)));
      n = int'($urandom_range(8, 1));
      for (int k = 0; k < n; k++) begin
        writeCmd(1'($urandom_range(1)), ($urandom_range(4) != 0),
                 ($urandom_range(7) == 0) ? 8'd255 : 8'($urandom_range(12)));
      end
      applyStimulus(1, int'($urandom_range(100, 30)), int'($urandom_range(3)), 1'b1);
      applyStimulus(1, 100, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
